imem_loader: RTL and testbench

Write-side companion to the instruction memory. Accepts a length-prefixed program image as a byte stream (valid/ready, typically from the host UART receiver), packs bytes into 16-bit instruction words, and drives the instruction-memory write port at consecutive addresses starting from 0. Holds the processor cores in hold while loading, and reports completion or error.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_checksum.sv | 25 ++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDatHi,
        StDatLo,
        StWrite,
        StChk,
        StDone,
        StErr
    } state_e;

    localparam int unsigned FRAME_HDR_BYTES = 2;
    localparam int unsigned CHK_BYTES       = 1;

endpackage

// File: rtl/imem_checksum.sv
// 8-bit running-sum accumulator used to validate a loaded frame.
module imem_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       accumulate,
    input  logic [7:0] data,
    output logic       match
);

    logic [7:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'h00;
        end else if (clear) begin
            sum_q <= 8'h00;
        end else if (accumulate) begin
            sum_q <= sum_q + data;
        end
    end

    assign match = (sum_q == data);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the cores.
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_WORDS = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    state_e            state;
    logic [7:0]        len_hi_q;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] len_q;
    logic [15:0]       len_word;
    logic              last_word;

    assign len_word  = {len_hi_q, in_data};
    // word_count doubles as the write index; it is incremented on leaving WRITE
    assign last_word = ((word_count + ADDR_W'(1)) == len_q);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic chk_match;

    imem_checksum u_checksum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start && (state == StIdle || state == StDone || state == StErr)),
        .accumulate (in_valid && in_ready && (state != StChk)),
        .data       (in_data),
        .match      (chk_match)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            len_hi_q   <= 8'h00;
            hi_q       <= 8'h00;
            len_q      <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 16'h0000;
            core_hold  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state      <= StLenHi;
                        in_ready   <= 1'b1;
                        core_hold  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
                    end
                end
                StLenHi: begin
                    if (in_valid) begin
                        len_hi_q <= in_data;
                        state    <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (in_valid) begin
                        if (len_word == 16'h0000 || 32'(len_word) > MAX_WORDS) begin
                            state    <= StErr;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            len_q <= ADDR_W'(len_word);
                            state <= StDatHi;
                        end
                    end
                end
                StDatHi: begin
                    if (in_valid) begin
                        hi_q  <= in_data;
                        state <= StDatLo;
                    end
                end
                StDatLo: begin
                    if (in_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_count;
                        mem_wdata <= {hi_q, in_data};
                        in_ready  <= 1'b0;
                        state     <= StWrite;
                    end
                end
                StWrite: begin
                    word_count <= word_count + ADDR_W'(1);
                    if (!last_word) begin
                        state    <= StDatHi;
                        in_ready <= 1'b1;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= StChk;
                        in_ready <= 1'b1;
`else
                        state     <= StDone;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StChk: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (chk_match) begin
                            state     <= StDone;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= StErr;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= StIdle;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames vs a frame-level model.
module tb_imem_loader;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned MAX_WORDS = 100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] word_count;

    int tests = 0;
    int fails = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [15:0]       wr_data[$];
    logic [15:0]       frame_words[$];

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Every write strobe is exactly one cycle, so one sample per falling edge sees it once.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/in_ready"}, 32'(in_ready), 0);
        check({tag, "/mem_we"}, 32'(mem_we), 0);
        check({tag, "/mem_addr"}, 32'(mem_addr), 0);
        check({tag, "/mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "/core_hold"}, 32'(core_hold), 0);
        check({tag, "/done"}, 32'(done), 0);
        check({tag, "/error"}, 32'(error), 0);
        check({tag, "/word_count"}, 32'(word_count), 0);
    endtask

    // Called at a falling edge; returns at the falling edge just after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) check("byte_timeout", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle per byte, 2 random 0..3 idle cycles
    task automatic run_frame(input string name, input int unsigned len, input int gap_mode,
                             input int start_at, input bit chk_bad);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        bit         len_ok;
        bit         exp_err;
        int         gap;

        len_ok = (len != 0) && (len <= MAX_WORDS);
        bytes.push_back(len[15:8]);
        bytes.push_back(len[7:0]);
        if (len_ok) begin
            for (int i = 0; i < int'(len); i++) begin
                bytes.push_back(frame_words[i][15:8]);
                bytes.push_back(frame_words[i][7:0]);
            end
        end
        exp_err = !len_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (len_ok) begin
            sum = 8'h00;
            foreach (bytes[i]) sum = sum + bytes[i];
            bytes.push_back(sum + 8'(chk_bad));
            exp_err = chk_bad;
        end
`else
        sum = 8'(chk_bad);
`endif

        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        check({name, "/ready_after_start"}, 32'(in_ready), 1);
        check({name, "/cleared"}, {29'b0, done, error, core_hold}, 3'b001);
        check({name, "/wc_cleared"}, 32'(word_count), 0);

        for (int i = 0; i < bytes.size(); i++) begin
            if (i == start_at) pulse_start();
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
            send_byte(bytes[i], gap);
        end

        if (!len_ok) begin
            check({name, "/len_err_now"}, {30'b0, error, in_ready}, 2'b10);
            check({name, "/len_err_no_we"}, 32'(mem_we), 0);
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            check({name, "/chk_result_now"}, {30'b0, done, error}, exp_err ? 2'b01 : 2'b10);
`else
            check({name, "/last_we"}, {30'b0, mem_we, done}, 2'b10);
            check({name, "/last_addr"}, 32'(mem_addr), len - 1);
            @(negedge clk);
            check({name, "/done_next"}, {30'b0, done, core_hold}, 2'b10);
`endif
        end

        repeat (3) @(negedge clk);
        check({name, "/n_writes"}, 32'(wr_addr.size()), len_ok ? len : 0);
        if (len_ok && wr_addr.size() == len) begin
            for (int i = 0; i < int'(len); i++) begin
                check({name, "/wr_addr"}, 32'(wr_addr[i]), i);
                check({name, "/wr_data"}, 32'(wr_data[i]), 32'(frame_words[i]));
            end
        end
        check({name, "/done"}, 32'(done), !exp_err);
        check({name, "/error"}, 32'(error), exp_err);
        check({name, "/core_hold"}, 32'(core_hold), exp_err);
        check({name, "/in_ready"}, 32'(in_ready), 0);
        check({name, "/word_count"}, 32'(word_count), len_ok ? len : 0);
    endtask

    initial begin
        int unsigned len;
        int unsigned r;

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        frame_words = {16'h0000, 16'h03E6, 16'h0001};
        run_frame("basic", 3, 0, -1, 1'b0);
        run_frame("len101", 101, 0, -1, 1'b0);
        run_frame("len0", 0, 0, -1, 1'b0);
        run_frame("gappy", 3, 1, -1, 1'b0);
        run_frame("mid_start", 3, 0, 4, 1'b0);

        // Reset after the first word is written, then a full reload from address 0.
        frame_words = {16'h1111, 16'h2222, 16'h3333};
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_reset/one_write", 32'(wr_addr.size()), 1);
        check("mid_reset/quiet", 32'(in_ready), 0);
        run_frame("after_reset", 3, 0, -1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_words = {16'h0019, 16'h0007};
        run_frame("chk_good", 2, 0, -1, 1'b0);
        run_frame("chk_bad", 2, 0, -1, 1'b1);
`endif

        for (int n = 0; n < 25; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) len = 0;
            else if (r == 1) len = $urandom_range(101, 65535);
            else if (r == 2) len = MAX_WORDS;
            else len = $urandom_range(1, 8);
            frame_words.delete();
            for (int i = 0; i < 100; i++) frame_words.push_back(16'($urandom));
            run_frame("rand", len, 2, ($urandom_range(0, 3) == 0) ? 3 : -1,
                      1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
